// File: rtl/lut_neg_ln.sv
// Sequential -ln(y): 0.32 fraction in, 4.16 result out, one result bit per cycle by greedy restoring search.
// Latency 21 cycles (1 when y==0); requests are accepted only in IDLE, and requests arriving while busy are dropped.
module lut_neg_ln #(
    parameter int data_size = 32
) (
    input  logic                 clock_i,
    input  logic                 reset_n_i,
    input  logic [data_size-1:0] data_i,
    input  logic                 data_valid_i,
    output logic                 busy_o,
    output logic                 output_valid_o,
    output logic                 sat_o,
    output logic [data_size-1:0] data_o
);

    localparam logic [32:0] ONE = 33'h1_0000_0000;

    // T[k] = e^-(2^(k-16)) as a 0.32 fraction; the first entry is k = 19
    localparam logic [31:0] T_TABLE [19:0] = '{
        32'h0015FC21, 32'h04B0556E, 32'h22A55547, 32'h5E2D58D8, 32'h9B4597E3,
        32'hC75F7CF5, 32'hE1EB5127, 32'hF07D5FDE, 32'hF81FAB54, 32'hFC07F55F,
        32'hFE01FEAB, 32'hFF007FD5, 32'hFF801FFA, 32'hFFC007FF, 32'hFFE001FF,
        32'hFFF0007F, 32'hFFF8001F, 32'hFFFC0007, 32'hFFFE0002, 32'hFFFF0000
    };

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [31:0]            y_r;
    logic [32:0]            p;
    logic [19:0]            x_r;
    logic [4:0]             k;
    logic                   sat_r;
    logic [data_size-1:0]   data_r;
    logic                   sat_q;

    logic [32:0]            trial;
    logic                   take;
    logic [19:0]            x_upd;

    // p is at most 1.0 and T < 1.0, so the upper 33 bits of the product are the truncated 1.32 result
    always_comb begin
        trial    = 33'(({32'b0, p} * {33'b0, T_TABLE[k]}) >> 32);
        take     = (trial >= {1'b0, y_r});
        x_upd    = x_r;
        x_upd[k] = take;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (data_valid_i) begin
                    state_nxt = (data_i == '0) ? DONE : COMPUTE;
                end
            end
            COMPUTE: begin
                if (k == 5'd0) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            y_r    <= '0;
            p      <= '0;
            x_r    <= '0;
            k      <= '0;
            sat_r  <= 1'b0;
            data_r <= '0;
            sat_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (data_valid_i) begin
                        if (data_i != '0) begin
                            y_r   <= data_i;
                            p     <= ONE;
                            x_r   <= '0;
                            k     <= 5'd19;
                            sat_r <= 1'b0;
                        end else begin
                            // -ln(0) is unbounded: pin to full scale and flag it
                            x_r    <= 20'hFFFFF;
                            sat_r  <= 1'b1;
                            data_r <= {{(data_size-20){1'b0}}, 20'hFFFFF};
                            sat_q  <= 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    x_r <= x_upd;
                    if (take) begin
                        p <= trial;
                    end
                    if (k == 5'd0) begin
                        // publish on entry to DONE so data_o is valid alongside the strobe
                        data_r <= {{(data_size-20){1'b0}}, x_upd};
                        sat_q  <= sat_r;
                    end else begin
                        k <= k - 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o         = (state != IDLE);
    assign output_valid_o = (state == DONE);
    assign sat_o          = sat_q;
    assign data_o         = data_r;

endmodule

// File: tb/tb_lut_neg_ln.sv
// Scoreboard bench for lut_neg_ln: directed requests push expected results, a negedge monitor pops and compares on each strobe.
module tb_lut_neg_ln;

    logic        clock;
    logic        reset_n;
    logic [31:0] data_in;
    logic        data_valid;
    logic        busy;
    logic        out_valid;
    logic        sat;
    logic [31:0] data_out;

    lut_neg_ln #(.data_size(32)) dut (
        .clock_i        (clock),
        .reset_n_i      (reset_n),
        .data_i         (data_in),
        .data_valid_i   (data_valid),
        .busy_o         (busy),
        .output_valid_o (out_valid),
        .sat_o          (sat),
        .data_o         (data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] d;
        logic        s;
    } want_t;

    want_t sb[$];
    int    checks  = 0;
    int    errors  = 0;
    int    nstrobe = 0;
    logic  prev_vld = 1'b0;

    localparam bit [31:0] TB_T [20] = '{
        32'hFFFF0000, 32'hFFFE0002, 32'hFFFC0007, 32'hFFF8001F, 32'hFFF0007F,
        32'hFFE001FF, 32'hFFC007FF, 32'hFF801FFA, 32'hFF007FD5, 32'hFE01FEAB,
        32'hFC07F55F, 32'hF81FAB54, 32'hF07D5FDE, 32'hE1EB5127, 32'hC75F7CF5,
        32'h9B4597E3, 32'h5E2D58D8, 32'h22A55547, 32'h04B0556E, 32'h0015FC21
    };

    function automatic logic [19:0] model_x(input logic [31:0] y);
        longint unsigned pp = 64'h1_0000_0000;
        longint unsigned tr;
        logic [19:0]     x  = '0;
        if (y == 32'h0) return 20'hFFFFF;
        for (int kk = 19; kk >= 0; kk--) begin
            tr = (pp * {32'h0, TB_T[kk]}) >> 32;
            if (tr >= {32'h0, y}) begin
                pp    = tr;
                x[kk] = 1'b1;
            end
        end
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n && out_valid) begin
            want_t w;
            nstrobe++;
            checks++;
            if (prev_vld) begin
                errors++;
                $display("FAIL strobe_twice: output_valid high on consecutive cycles");
            end
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got data %h sat %b, expected no strobe", data_out, sat);
            end else begin
                w = sb.pop_front();
                chk("result_data", data_out, w.d);
                chk("result_sat", {31'b0, sat}, {31'b0, w.s});
            end
        end
        prev_vld = out_valid;
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clock);
        while (busy && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy still 1 after %0d cycles, expected 0", n);
        end
    endtask

    task automatic do_req(input logic [31:0] y, input logic [19:0] wx, input int wlat);
        int n;
        int lat;
        int bcnt;
        wait_idle();
        data_in    = y;
        data_valid = 1'b1;
        sb.push_back('{d: {12'b0, wx}, s: (y == 32'h0)});
        @(negedge clock);
        data_valid = 1'b0;
        n    = 1;
        lat  = 0;
        bcnt = 0;
        while (n <= 60) begin
            if (out_valid) lat = n;
            if (busy) bcnt++;
            else break;
            n++;
            @(negedge clock);
        end
        chk("latency", lat, wlat);
        chk("busy_cycles", bcnt, wlat);
    endtask

    initial begin
        logic [31:0] y;
        logic [31:0] f;
        int          s0;

        reset_n    = 1'b0;
        data_valid = 1'b0;
        data_in    = '0;
        repeat (3) @(negedge clock);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_valid", {31'b0, out_valid}, 32'h0);
        chk("reset_sat", {31'b0, sat}, 32'h0);
        chk("reset_data", data_out, 32'h0);
        reset_n = 1'b1;

        do_req(32'h5E2D58D8, 20'h10000, 21);
        do_req(32'hFFFFFFFF, 20'h00000, 21);
        do_req(32'h0015FC21, 20'h80000, 21);
        do_req(32'hFC07F55F, 20'h00400, 21);
        do_req(32'hFFFF0000, 20'h00001, 21);
        do_req(32'h80000000, model_x(32'h80000000), 21);
        checks++;
        if (data_out < 32'h0000B171 || data_out > 32'h0000B173) begin
            errors++;
            $display("FAIL ln2_range: got %h expected 0000B172 +/-1", data_out);
        end

        do_req(32'h00000000, 20'hFFFFF, 1);
        repeat (3) @(negedge clock);
        chk("sat_hold_data", data_out, 32'h000FFFFF);
        chk("sat_hold_sat", {31'b0, sat}, 32'h1);
        do_req(32'h5E2D58D8, 20'h10000, 21);

        // valid held high: only the values present at the IDLE edges (every 22 cycles) are taken
        wait_idle();
        s0 = nstrobe;
        for (int n = 0; n < 66; n++) begin
            f          = n * 32'h9E3779B9 + 32'd1;
            data_in    = f;
            data_valid = 1'b1;
            if (n % 22 == 0) sb.push_back('{d: {12'b0, model_x(f)}, s: (f == 32'h0)});
            @(negedge clock);
        end
        data_valid = 1'b0;
        wait_idle();
        chk("held_valid_strobes", nstrobe - s0, 32'd3);

        for (int i = 0; i < 16; i++) begin
            y = $urandom;
            do_req(y, model_x(y), (y == 32'h0) ? 1 : 21);
        end

        // asynchronous reset while k = 10: outputs clear at once and the result is dropped
        wait_idle();
        data_in    = 32'h12345678;
        data_valid = 1'b1;
        @(negedge clock);
        data_valid = 1'b0;
        repeat (9) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_busy", {31'b0, busy}, 32'h0);
        chk("arst_valid", {31'b0, out_valid}, 32'h0);
        chk("arst_sat", {31'b0, sat}, 32'h0);
        chk("arst_data", data_out, 32'h0);
        s0 = nstrobe;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (30) @(negedge clock);
        chk("arst_no_strobe", nstrobe - s0, 32'd0);
        do_req(32'h0015FC21, 20'h80000, 21);

        repeat (3) @(negedge clock);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
